// File: rtl/sha3_core_arbiter.sv
// Round-robin arbiter sharing one SHA3-256 core among N_REQ word-stream sources, one message at a time.
// Optional idle-word watchdog and sticky timeout_err port enabled by defining SHA3_ARB_TIMEOUT_EN.
module sha3_core_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ*64-1:0]  req_in,
    input  logic [N_REQ-1:0]     req_in_ready,
    input  logic [N_REQ-1:0]     req_is_last,
    input  logic [N_REQ*4-1:0]   req_byte_num,
    output logic [N_REQ-1:0]     req_buffer_full,
    output logic [N_REQ-1:0]     req_grant,
    output logic [255:0]         hash_out,
    output logic [N_REQ-1:0]     hash_valid,
    input  logic                 hash_ack,
    output logic                 core_reset,
    output logic [63:0]          core_in,
    output logic                 core_in_ready,
    output logic                 core_is_last,
    output logic [3:0]           core_byte_num,
    input  logic                 core_buffer_full,
    input  logic [255:0]         core_out,
    input  logic                 core_out_ready
`ifdef SHA3_ARB_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int unsigned TMO_W = 16;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLR     = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_DELIVER = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] hash_valid_q, hash_valid_d;
    logic [255:0]     hash_out_q, hash_out_d;
    logic             core_reset_q, core_reset_d;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic [63:0]      slot_in [N_REQ];
    logic [3:0]       slot_bn [N_REQ];
    logic             hit;
    logic [PTR_W-1:0] hit_idx;
    logic [PTR_W-1:0] cand_idx;
    logic             accepted;

`ifdef SHA3_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;
    assign timeout_err = tmo_err_q;
`endif

    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_slot
        assign slot_in[g] = req_in[g*64 +: 64];
        assign slot_bn[g] = req_byte_num[g*4 +: 4];
    end

    // Round-robin search starting one past the previous owner.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        cand_idx = '0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            cand_idx = PTR_W'((int'(rr_ptr_q) + i) % int'(N_REQ));
            if (!hit && req_in_ready[cand_idx]) begin
                hit     = 1'b1;
                hit_idx = cand_idx;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        owner_d         = owner_q;
        grant_d         = grant_q;
        hash_valid_d    = hash_valid_q;
        hash_out_d      = hash_out_q;
        core_reset_d    = core_reset_q;
        clr_cnt_d       = clr_cnt_q;
        core_in         = '0;
        core_byte_num   = '0;
        core_in_ready   = 1'b0;
        core_is_last    = 1'b0;
        req_buffer_full = '1;
        accepted        = 1'b0;
`ifdef SHA3_ARB_TIMEOUT_EN
        tmo_cnt_d       = tmo_cnt_q;
        tmo_err_d       = tmo_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    owner_d      = hit_idx;
                    grant_d      = N_REQ'(1) << hit_idx;
                    clr_cnt_d    = '0;
                    core_reset_d = 1'b1;
                    state_d      = S_CLR;
                end
            end
            S_CLR: begin
                if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
                    core_reset_d = 1'b0;
                    state_d      = S_STREAM;
`ifdef SHA3_ARB_TIMEOUT_EN
                    tmo_cnt_d    = '0;
`endif
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            S_STREAM: begin
                // Owner's stream is a pure combinational pass-through to the core.
                core_in                  = slot_in[owner_q];
                core_byte_num            = slot_bn[owner_q];
                core_in_ready            = req_in_ready[owner_q];
                core_is_last             = req_is_last[owner_q] & req_in_ready[owner_q];
                req_buffer_full[owner_q] = core_buffer_full;
                accepted                 = core_in_ready & ~core_buffer_full;
                if (accepted && core_is_last) begin
                    state_d = S_WAIT;
                end
`ifdef SHA3_ARB_TIMEOUT_EN
                if (accepted) begin
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (tmo_cnt_d == TMO_W'(TIMEOUT)) begin
                        rr_ptr_d     = owner_q;
                        grant_d      = '0;
                        core_reset_d = 1'b1;
                        tmo_err_d    = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
`endif
            end
            S_WAIT: begin
                if (core_out_ready) begin
                    hash_out_d   = core_out;
                    hash_valid_d = grant_q;
                    state_d      = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (hash_ack) begin
                    hash_valid_d = '0;
                    rr_ptr_d     = owner_q;
                    grant_d      = '0;
                    core_reset_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                grant_d      = '0;
                hash_valid_d = '0;
                core_reset_d = 1'b1;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            grant_q      <= '0;
            hash_valid_q <= '0;
            hash_out_q   <= '0;
            core_reset_q <= 1'b1;
            clr_cnt_q    <= '0;
`ifdef SHA3_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            tmo_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            hash_valid_q <= hash_valid_d;
            hash_out_q   <= hash_out_d;
            core_reset_q <= core_reset_d;
            clr_cnt_q    <= clr_cnt_d;
`ifdef SHA3_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            tmo_err_q    <= tmo_err_d;
`endif
        end
    end

    assign req_grant  = grant_q;
    assign hash_valid = hash_valid_q;
    assign hash_out   = hash_out_q;
    assign core_reset = core_reset_q;

endmodule

// File: tb/tb_sha3_core_arbiter.sv
// Directed bench for sha3_core_arbiter: arbitration order, clear phase, stream muxing, stalls, delivery, reset.
module tb_sha3_core_arbiter;

    localparam int unsigned N_REQ      = 4;
    localparam int unsigned CLR_CYCLES = 2;
    localparam int unsigned TIMEOUT    = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] req_in;
    logic [3:0]   req_in_ready;
    logic [3:0]   req_is_last;
    logic [15:0]  req_byte_num;
    logic [3:0]   req_buffer_full;
    logic [3:0]   req_grant;
    logic [255:0] hash_out;
    logic [3:0]   hash_valid;
    logic         hash_ack;
    logic         core_reset;
    logic [63:0]  core_in;
    logic         core_in_ready;
    logic         core_is_last;
    logic [3:0]   core_byte_num;
    logic         core_buffer_full;
    logic [255:0] core_out;
    logic         core_out_ready;
`ifdef SHA3_ARB_TIMEOUT_EN
    logic         timeout_err;
`endif

    logic [63:0]  w_in  [4];
    logic [3:0]   bn_in [4];
    logic         rdy   [4];
    logic         lst   [4];

    int           n_tests = 0;
    int           n_fail  = 0;
    int           acc_cnt = 0;
    logic [63:0]  last_word = '0;
    logic [3:0]   last_bn   = '0;

    sha3_core_arbiter #(
        .N_REQ      (N_REQ),
        .CLR_CYCLES (CLR_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_in           (req_in),
        .req_in_ready     (req_in_ready),
        .req_is_last      (req_is_last),
        .req_byte_num     (req_byte_num),
        .req_buffer_full  (req_buffer_full),
        .req_grant        (req_grant),
        .hash_out         (hash_out),
        .hash_valid       (hash_valid),
        .hash_ack         (hash_ack),
        .core_reset       (core_reset),
        .core_in          (core_in),
        .core_in_ready    (core_in_ready),
        .core_is_last     (core_is_last),
        .core_byte_num    (core_byte_num),
        .core_buffer_full (core_buffer_full),
        .core_out         (core_out),
        .core_out_ready   (core_out_ready)
`ifdef SHA3_ARB_TIMEOUT_EN
        ,
        .timeout_err      (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        req_in       = {w_in[3], w_in[2], w_in[1], w_in[0]};
        req_byte_num = {bn_in[3], bn_in[2], bn_in[1], bn_in[0]};
        req_in_ready = {rdy[3], rdy[2], rdy[1], rdy[0]};
        req_is_last  = {lst[3], lst[2], lst[1], lst[0]};
    end

    // Core-side view: every word the core would take, and the final word seen.
    always @(posedge clk) begin
        if (reset && core_in_ready && !core_buffer_full) begin
            acc_cnt = acc_cnt + 1;
            if (core_is_last) begin
                last_word = core_in;
                last_bn   = core_byte_num;
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] word_of(input logic [1:0] k, input int j);
        return {32'hA5A5_0000 | 32'(k), 32'(j)};
    endfunction

    function automatic logic [255:0] dig_of(input logic [1:0] k, input logic [5:0] salt);
        return {8{24'hD16E57, salt, k}};
    endfunction

    task automatic pend(input logic [1:0] k, input logic [3:0] bn);
        w_in[k]  = word_of(k, 0);
        bn_in[k] = bn;
        lst[k]   = 1'b1;
        rdy[k]   = 1'b1;
    endtask

    // One full message for requester k, optional core stall of stall_len cycles at word stall_at.
    task automatic run_msg(input logic [1:0] k, input int nw, input logic [3:0] lastb,
                           input logic [255:0] dig, input int stall_at, input int stall_len);
        int j = 0;
        int cyc = 0;
        int clr_cyc = 0;
        int base;
        int left;
        bit seen = 1'b0;
        bit stall_seen = 1'b0;
        base = acc_cnt;
        left = stall_len;
        while (j < nw && cyc < 300) begin
            w_in[k]  = word_of(k, j);
            rdy[k]   = 1'b1;
            lst[k]   = (j == nw - 1);
            bn_in[k] = (j == nw - 1) ? lastb : 4'd0;
            core_buffer_full = (j == stall_at) && (left > 0) && (req_grant != 4'd0) && !core_reset;
            #1;
            if (!seen && req_grant != 4'd0) begin
                seen = 1'b1;
                check("grant_owner", 256'(req_grant), 256'(4'(1) << k));
            end
            if (req_grant[k] && core_reset) clr_cyc++;
            if (core_buffer_full) begin
                left--;
                if (!stall_seen) begin
                    stall_seen = 1'b1;
                    check("stall_bfull", 256'(req_buffer_full[k]), 256'(1));
                end
            end
            if (!req_buffer_full[k]) j++;
            tick();
            cyc++;
        end
        core_buffer_full = 1'b0;
        check("stream_done", 256'(j), 256'(nw));
        rdy[k] = 1'b0;
        lst[k] = 1'b0;
        #1;
        check("wait_in_ready", 256'(core_in_ready), 256'(0));
        check("wait_bfull", 256'(req_buffer_full[k]), 256'(1));
        check("clr_cycles", 256'(clr_cyc), 256'(CLR_CYCLES));
        check("word_count", 256'(acc_cnt - base), 256'(nw));
        check("last_word", 256'(last_word), 256'(word_of(k, nw - 1)));
        check("last_bytes", 256'(last_bn), 256'(lastb));
        hash_ack = 1'b1;
        tick();
        hash_ack = 1'b0;
        #1;
        check("ack_in_wait", 256'(hash_valid), 256'(0));
        core_out       = dig;
        core_out_ready = 1'b1;
        tick();
        core_out_ready = 1'b0;
        core_out       = ~dig;
        #1;
        check("hash_valid", 256'(hash_valid), 256'(4'(1) << k));
        check("hash_out", hash_out, dig);
        core_out_ready = 1'b1;
        tick();
        core_out_ready = 1'b0;
        #1;
        check("hash_hold", hash_out, dig);
        hash_ack = 1'b1;
        tick();
        hash_ack = 1'b0;
        #1;
        check("ack_valid", 256'(hash_valid), 256'(0));
        check("ack_grant", 256'(req_grant), 256'(0));
        check("ack_core_rst", 256'(core_reset), 256'(1));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            w_in[i]  = '0;
            bn_in[i] = '0;
            rdy[i]   = 1'b0;
            lst[i]   = 1'b0;
        end
        reset            = 1'b0;
        hash_ack         = 1'b0;
        core_buffer_full = 1'b0;
        core_out         = '0;
        core_out_ready   = 1'b0;
        tick();
        tick();
        check("rst_grant", 256'(req_grant), 256'(0));
        check("rst_valid", 256'(hash_valid), 256'(0));
        check("rst_hash", hash_out, 256'(0));
        check("rst_bfull", 256'(req_buffer_full), 256'(4'hF));
        check("rst_core_rst", 256'(core_reset), 256'(1));
        check("rst_in_ready", 256'(core_in_ready), 256'(0));
        check("rst_is_last", 256'(core_is_last), 256'(0));
`ifdef SHA3_ARB_TIMEOUT_EN
        check("rst_tmo_err", 256'(timeout_err), 256'(0));
`endif
        reset = 1'b1;

        // Single requester, three words, four bytes in the last.
        run_msg(2'd0, 3, 4'd4, dig_of(2'd0, 6'd1), -1, 0);

        // All four request at once after reset: order 1,2,3,0.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) pend(2'(i), 4'd0);
        run_msg(2'd1, 1, 4'd0, dig_of(2'd1, 6'd2), -1, 0);
        run_msg(2'd2, 1, 4'd0, dig_of(2'd2, 6'd2), -1, 0);
        run_msg(2'd3, 1, 4'd0, dig_of(2'd3, 6'd2), -1, 0);
        run_msg(2'd0, 1, 4'd0, dig_of(2'd0, 6'd2), -1, 0);

        // Core back-pressure for 17 cycles mid-message.
        run_msg(2'd2, 5, 4'd7, dig_of(2'd2, 6'd3), 2, 17);

        // Empty message: single last word with zero bytes.
        run_msg(2'd3, 1, 4'd0, dig_of(2'd3, 6'd4), -1, 0);

        // Pointer at N_REQ-1: lowest index wins.
        pend(2'd0, 4'd3);
        pend(2'd2, 4'd3);
        run_msg(2'd0, 1, 4'd3, dig_of(2'd0, 6'd5), -1, 0);
        run_msg(2'd2, 1, 4'd3, dig_of(2'd2, 6'd5), -1, 0);

        // Reset while waiting for the digest.
        begin
            int c = 0;
            pend(2'd1, 4'd5);
            #1;
            while (req_buffer_full[1] && c < 50) begin
                tick();
                c++;
            end
            check("t5_reached_stream", 256'(c < 50), 256'(1));
            tick();
            rdy[1] = 1'b0;
            lst[1] = 1'b0;
            #1;
            check("t5_in_wait", 256'(core_in_ready), 256'(0));
            reset = 1'b0;
            tick();
            check("t5_grant", 256'(req_grant), 256'(0));
            check("t5_valid", 256'(hash_valid), 256'(0));
            check("t5_core_rst", 256'(core_reset), 256'(1));
            check("t5_bfull", 256'(req_buffer_full), 256'(4'hF));
            reset = 1'b1;
        end
        pend(2'd3, 4'd1);
        pend(2'd1, 4'd1);
        run_msg(2'd1, 1, 4'd1, dig_of(2'd1, 6'd6), -1, 0);
        run_msg(2'd3, 1, 4'd1, dig_of(2'd3, 6'd6), -1, 0);

`ifdef SHA3_ARB_TIMEOUT_EN
        // Owner 0 stalls after one word; watchdog aborts and requester 1 is served.
        begin
            int c = 0;
            w_in[0]  = word_of(2'd0, 0);
            bn_in[0] = 4'd0;
            lst[0]   = 1'b0;
            rdy[0]   = 1'b1;
            pend(2'd1, 4'd2);
            #1;
            while (!(req_grant == 4'b0001 && !req_buffer_full[0]) && c < 50) begin
                tick();
                c++;
            end
            check("t6_stream", 256'(c < 50), 256'(1));
            tick();
            rdy[0] = 1'b0;
            c = 0;
            while (req_grant[0] && c < 40) begin
                tick();
                c++;
            end
            check("t6_abort_cycles", 256'(c), 256'(TIMEOUT));
            check("t6_tmo_err", 256'(timeout_err), 256'(1));
            check("t6_valid", 256'(hash_valid), 256'(0));
        end
        run_msg(2'd1, 1, 4'd2, dig_of(2'd1, 6'd7), -1, 0);
        check("t6_tmo_sticky", 256'(timeout_err), 256'(1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
